// File: rtl/decode_pkg.sv
// decode_pkg
//   Shared definitions for the decode stage slice.
//   - Default widths for the stage parameters (instruction, register select,
//     raw immediate, extended immediate, ALU opcode, scoreboard depth).
//   - Field offset helpers. Every field position is derived from the
//     parameter widths, so a non-default build still has a consistent layout.
//     At the defaults the layout is:
//       imm[15:0]  rs2[15:11]  rs1[20:16]  ws[25:21]  op[28:26]  dsrc[29]
//   - decoded_t: the decoded-field bundle at the default widths, for
//     consumers that work with the default configuration.
package decode_pkg;

  localparam int INSTR_W_DEF   = 32;
  localparam int REG_AW_DEF    = 5;
  localparam int IMM_W_DEF     = 16;
  localparam int DATA_W_DEF    = 32;
  localparam int OP_W_DEF      = 3;
  localparam int HAZ_DEPTH_DEF = 2;

  // The raw immediate always starts at bit 0.
  localparam int IMM_LSB = 0;

  // rs2 overlaps the top REG_AW bits of the raw immediate.
  function automatic int rs2_lsb(input int imm_w, input int reg_aw);
    return imm_w - reg_aw;
  endfunction

  function automatic int rs1_lsb(input int imm_w);
    return imm_w;
  endfunction

  function automatic int ws_lsb(input int imm_w, input int reg_aw);
    return imm_w + reg_aw;
  endfunction

  function automatic int op_lsb(input int imm_w, input int reg_aw);
    return imm_w + 2 * reg_aw;
  endfunction

  function automatic int dsrc_bit(input int imm_w, input int reg_aw, input int op_w);
    return imm_w + 2 * reg_aw + op_w;
  endfunction

  typedef struct packed {
    logic [REG_AW_DEF-1:0] rs1;
    logic [REG_AW_DEF-1:0] rs2;
    logic [REG_AW_DEF-1:0] ws;
    logic                  we;
    logic [DATA_W_DEF-1:0] imm;
    logic                  data_src;
    logic [OP_W_DEF-1:0]   alu_op;
  } decoded_t;

endpackage

// File: rtl/decode_scoreboard.sv
// decode_scoreboard
//   Remembers the destination registers of the last HAZ_DEPTH instructions
//   that left the decode stage, and flags a read of any of them.
//   Ports:
//     clk, rst            clock, async active-high reset
//     flush               invalidate every entry on the next edge
//     push_valid/push_sel head entry for this cycle (valid = a real write)
//     rd_sel1/rd_sel2     read selects of the incoming instruction
//     hit                 a nonzero read select matches a valid entry
//   HAZ_DEPTH is expected to be in the range 1..4.
module decode_scoreboard
  import decode_pkg::*;
#(
  parameter int REG_AW    = REG_AW_DEF,
  parameter int HAZ_DEPTH = HAZ_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push_valid,
  input  logic [REG_AW-1:0] push_sel,
  input  logic [REG_AW-1:0] rd_sel1,
  input  logic [REG_AW-1:0] rd_sel2,
  output logic              hit
);

  logic [HAZ_DEPTH-1:0] ent_valid;
  logic [REG_AW-1:0]    ent_sel [HAZ_DEPTH];

  // The shift register advances every cycle, with or without a push, so an
  // entry ages out exactly HAZ_DEPTH cycles after it was written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_valid <= '0;
      for (int i = 0; i < HAZ_DEPTH; i++) ent_sel[i] <= '0;
    end else begin
      for (int i = HAZ_DEPTH - 1; i > 0; i--) begin
        ent_valid[i] <= flush ? 1'b0 : ent_valid[i-1];
        ent_sel[i]   <= ent_sel[i-1];
      end
      ent_valid[0] <= flush ? 1'b0 : push_valid;
      ent_sel[0]   <= push_sel;
    end
  end

  // Register 0 is never a real dependency, so zero selects never match.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < HAZ_DEPTH; i++) begin
      if (ent_valid[i] &&
          (((rd_sel1 != '0) && (rd_sel1 == ent_sel[i])) ||
           ((rd_sel2 != '0) && (rd_sel2 == ent_sel[i]))))
        hit = 1'b1;
    end
  end

endmodule

// File: rtl/decode_stage_reg.sv
// decode_stage_reg
//   Decode pipeline register: splits the raw instruction into register
//   selects, opcode, operand-source bit and extended immediate, and holds
//   them in a single-entry valid/ready register.
//   Optional hazard interlock, enabled by defining DECODE_HAZARD_EN: a
//   decode_scoreboard tracks recent destinations and 'stall' blocks an
//   instruction that reads one of them. Without the macro, stall is 0.
//   Ports:
//     clk, rst                      clock, async active-high reset
//     in_valid, InstrIn, in_ready   upstream handshake and instruction
//     flush                         drop held and incoming instruction
//     out_valid, out_ready          downstream handshake
//     S1_ReadSelect1/2, S1_WriteSelect, S1_WriteEnable,
//     immediate, data_src, ALU_OP   decoded fields
//     stall                         hazard interlock (combinational)
module decode_stage_reg
  import decode_pkg::*;
#(
  parameter int INSTR_W   = INSTR_W_DEF,
  parameter int REG_AW    = REG_AW_DEF,
  parameter int IMM_W     = IMM_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int OP_W      = OP_W_DEF,
  parameter int HAZ_DEPTH = HAZ_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [INSTR_W-1:0] InstrIn,
  output logic              in_ready,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_AW-1:0] S1_ReadSelect1,
  output logic [REG_AW-1:0] S1_ReadSelect2,
  output logic [REG_AW-1:0] S1_WriteSelect,
  output logic              S1_WriteEnable,
  output logic [DATA_W-1:0] immediate,
  output logic              data_src,
  output logic [OP_W-1:0]   ALU_OP,
  output logic              stall
);

  localparam int RS1_LSB  = rs1_lsb(IMM_W);
  localparam int RS2_LSB  = rs2_lsb(IMM_W, REG_AW);
  localparam int WS_LSB   = ws_lsb(IMM_W, REG_AW);
  localparam int OP_LSB   = op_lsb(IMM_W, REG_AW);
  localparam int DSRC_BIT = dsrc_bit(IMM_W, REG_AW, OP_W);

  logic [REG_AW-1:0] dec_rs1, dec_rs2, dec_ws;
  logic [IMM_W-1:0]  dec_imm_raw;
  logic [DATA_W-1:0] dec_imm;
  logic              dec_dsrc;
  logic [OP_W-1:0]   dec_op;
  logic              accept, transfer;

  assign dec_rs1     = InstrIn[RS1_LSB +: REG_AW];
  assign dec_rs2     = InstrIn[RS2_LSB +: REG_AW];
  assign dec_ws      = InstrIn[WS_LSB +: REG_AW];
  assign dec_imm_raw = InstrIn[IMM_LSB +: IMM_W];
  assign dec_op      = InstrIn[OP_LSB +: OP_W];
  assign dec_dsrc    = InstrIn[DSRC_BIT];

  // The size cast of a signed operand sign-extends; of an unsigned one,
  // zero-extends. This also stays legal when DATA_W equals IMM_W.
  assign dec_imm = dec_dsrc ? DATA_W'($signed(dec_imm_raw)) : DATA_W'(dec_imm_raw);

  // Instruction bits above the operand-source bit carry no decoded field.
  if (DSRC_BIT + 1 < INSTR_W) begin : g_spare
    logic unused_hi;
    assign unused_hi = ^InstrIn[INSTR_W-1:DSRC_BIT+1];
  end

  assign transfer = out_valid && out_ready;

`ifdef DECODE_HAZARD_EN
  logic hold_hit, sb_hit;

  // The held instruction has not reached the scoreboard yet, so its
  // destination is checked here directly.
  assign hold_hit = out_valid && S1_WriteEnable &&
                    (((dec_rs1 != '0) && (dec_rs1 == S1_WriteSelect)) ||
                     ((dec_rs2 != '0) && (dec_rs2 == S1_WriteSelect)));

  decode_scoreboard #(
    .REG_AW    (REG_AW),
    .HAZ_DEPTH (HAZ_DEPTH)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push_valid (transfer && S1_WriteEnable),
    .push_sel   (S1_WriteSelect),
    .rd_sel1    (dec_rs1),
    .rd_sel2    (dec_rs2),
    .hit        (sb_hit)
  );

  assign stall = in_valid && (hold_hit || sb_hit);
`else
  localparam int unused_haz_depth = HAZ_DEPTH;
  assign stall = 1'b0;
`endif

  // During a flush the incoming instruction is always consumed (and dropped).
  assign in_ready = flush || ((!out_valid || out_ready) && !stall);
  assign accept   = in_valid && in_ready && !flush;

  // Holding register. Flush beats a load; a load in the same cycle as a
  // transfer replaces the old entry and keeps out_valid high. The write
  // enable is cleared whenever the register empties so bubbles never write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid      <= 1'b0;
      S1_ReadSelect1 <= '0;
      S1_ReadSelect2 <= '0;
      S1_WriteSelect <= '0;
      S1_WriteEnable <= 1'b0;
      immediate      <= '0;
      data_src       <= 1'b0;
      ALU_OP         <= '0;
    end else if (flush) begin
      out_valid      <= 1'b0;
      S1_WriteEnable <= 1'b0;
    end else if (accept) begin
      out_valid      <= 1'b1;
      S1_ReadSelect1 <= dec_rs1;
      S1_ReadSelect2 <= dec_rs2;
      S1_WriteSelect <= dec_ws;
      S1_WriteEnable <= (dec_ws != '0);
      immediate      <= dec_imm;
      data_src       <= dec_dsrc;
      ALU_OP         <= dec_op;
    end else if (transfer) begin
      out_valid      <= 1'b0;
      S1_WriteEnable <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage_reg.sv
// tb_decode_stage_reg
//   Directed bench for decode_stage_reg at default parameters. Expected
//   decoded fields are produced by a reference decoder and queued when an
//   instruction is accepted; the queue front is compared against the DUT
//   outputs while it is held and popped when it transfers.
//   Works with and without DECODE_HAZARD_EN.
module tb_decode_stage_reg;
  import decode_pkg::*;

`ifdef DECODE_HAZARD_EN
  localparam bit HAZ = 1'b1;
`else
  localparam bit HAZ = 1'b0;
`endif
  localparam int HAZ_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] instr_in;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  rs1, rs2, ws;
  logic        we;
  logic [31:0] immediate;
  logic        data_src;
  logic [2:0]  alu_op;
  logic        stall;

  int          test_count = 0;
  int          fail_count = 0;
  decoded_t    exp_q[$];
  bit          model_valid = 1'b0;

  always #5 clk = ~clk;

  decode_stage_reg #(.HAZ_DEPTH(HAZ_DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .InstrIn        (instr_in),
    .in_ready       (in_ready),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .S1_ReadSelect1 (rs1),
    .S1_ReadSelect2 (rs2),
    .S1_WriteSelect (ws),
    .S1_WriteEnable (we),
    .immediate      (immediate),
    .data_src       (data_src),
    .ALU_OP         (alu_op),
    .stall          (stall)
  );

  // Build an instruction; rs2 is imm[15:11].
  function automatic logic [31:0] mk(input logic [2:0] op, input logic ds,
                                     input logic [4:0] wsel, input logic [4:0] r1,
                                     input logic [15:0] imm);
    return {2'b00, ds, op, wsel, r1, imm};
  endfunction

  // Reference decoder with the fixed default field map.
  function automatic decoded_t model(input logic [31:0] w);
    decoded_t d;
    d.rs1      = w[20:16];
    d.rs2      = w[15:11];
    d.ws       = w[25:21];
    d.we       = (w[25:21] != 5'd0);
    d.data_src = w[29];
    d.alu_op   = w[28:26];
    d.imm      = w[29] ? {{16{w[15]}}, w[15:0]} : {16'h0000, w[15:0]};
    return d;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    test_count++;
    assert (obs === expv)
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Compare the DUT holding register against the model.
  task automatic checkOutput(input string tag);
    decoded_t e;
    checkVal({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, model_valid});
    if (model_valid && exp_q.size() > 0) begin
      e = exp_q[0];
      checkVal({tag, " rs1"}, {27'd0, rs1}, {27'd0, e.rs1});
      checkVal({tag, " rs2"}, {27'd0, rs2}, {27'd0, e.rs2});
      checkVal({tag, " ws"}, {27'd0, ws}, {27'd0, e.ws});
      checkVal({tag, " we"}, {31'd0, we}, {31'd0, e.we});
      checkVal({tag, " imm"}, immediate, e.imm);
      checkVal({tag, " dsrc"}, {31'd0, data_src}, {31'd0, e.data_src});
      checkVal({tag, " op"}, {29'd0, alu_op}, {29'd0, e.alu_op});
    end else begin
      checkVal({tag, " bubble we"}, {31'd0, we}, 32'd0);
    end
  endtask

  // One cycle: drive at negedge, check handshake and held fields, then
  // update the model at the edge and check the register afterwards.
  task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic fl,
                               input logic ordy, input logic exp_ready,
                               input logic exp_stall, input string tag);
    bit acc, xfer;
    @(negedge clk);
    in_valid  = v;
    instr_in  = instr;
    flush     = fl;
    out_ready = ordy;
    #1;
    checkVal({tag, " in_ready"}, {31'd0, in_ready}, {31'd0, exp_ready});
    checkVal({tag, " stall"}, {31'd0, stall}, {31'd0, exp_stall});
    checkOutput({tag, " pre"});
    acc  = v && exp_ready && !fl;
    xfer = model_valid && ordy;
    @(posedge clk);
    #1;
    if (fl) begin
      exp_q.delete();
      model_valid = 1'b0;
    end else begin
      if (xfer) begin
        exp_q.delete(0);
        model_valid = 1'b0;
      end
      if (acc) begin
        exp_q.push_back(model(instr));
        model_valid = 1'b1;
      end
    end
    checkOutput({tag, " post"});
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, "drain");
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; instr_in = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkVal("reset out_valid", {31'd0, out_valid}, 32'd0);
    checkVal("reset imm", immediate, 32'd0);
    checkVal("reset ws", {27'd0, ws}, 32'd0);
    checkVal("reset in_ready", {31'd0, in_ready}, 32'd1);
    checkVal("reset stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Sign-extended decode with fixed expected values.
    applyStimulus(1'b1, 32'h2C22_8001, 1'b0, 1'b1, 1'b1, 1'b0, "dec_sext");
    checkVal("dec_sext imm const", immediate, 32'hFFFF_8001);
    checkVal("dec_sext rs2 const", {27'd0, rs2}, 32'd16);
    checkVal("dec_sext op const", {29'd0, alu_op}, 32'd3);

    // Zero-extended decode, loaded in the same cycle the previous one leaves.
    applyStimulus(1'b1, mk(3'd5, 1'b0, 5'd9, 5'd0, 16'h8701), 1'b0, 1'b1, 1'b1, 1'b0, "dec_zext");
    checkVal("dec_zext imm const", immediate, 32'h0000_8701);

    // Back-to-back random instructions that read only r0.
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b1, mk(3'($urandom), 1'($urandom), 5'($urandom), 5'd0,
                             16'($urandom) & 16'h07FF), 1'b0, 1'b1, 1'b1, 1'b0, "rand");
    drain(HAZ_DEPTH + 1);

    // Backpressure: held fields stay put, input is refused.
    applyStimulus(1'b1, mk(3'd2, 1'b1, 5'd7, 5'd3, 16'h1234), 1'b0, 1'b1, 1'b1, 1'b0, "bp_load");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, mk(3'd1, 1'b0, 5'd4, 5'd6, 16'h0042), 1'b0, 1'b0, 1'b0, 1'b0, "bp_hold");
    applyStimulus(1'b1, mk(3'd1, 1'b0, 5'd4, 5'd6, 16'h0042), 1'b0, 1'b1, 1'b1, 1'b0, "bp_release");
    drain(HAZ_DEPTH + 1);

    // Hazard via rs1: write r5, then read r5.
    applyStimulus(1'b1, mk(3'd0, 1'b0, 5'd5, 5'd1, 16'h0000), 1'b0, 1'b1, 1'b1, 1'b0, "haz_wr");
    for (int i = 0; i < HAZ_DEPTH + 1; i++)
      applyStimulus(1'b1, mk(3'd0, 1'b0, 5'd2, 5'd5, 16'h0000), 1'b0, 1'b1, !HAZ, HAZ, "haz_rs1");
    applyStimulus(1'b1, mk(3'd0, 1'b0, 5'd2, 5'd5, 16'h0000), 1'b0, 1'b1, 1'b1, 1'b0, "haz_rs1_go");
    drain(HAZ_DEPTH + 1);

    // Hazard via rs2: write r9, then read r9 through imm[15:11].
    applyStimulus(1'b1, mk(3'd0, 1'b0, 5'd9, 5'd0, 16'h0000), 1'b0, 1'b1, 1'b1, 1'b0, "haz2_wr");
    for (int i = 0; i < HAZ_DEPTH + 1; i++)
      applyStimulus(1'b1, mk(3'd0, 1'b0, 5'd1, 5'd0, 16'h4800), 1'b0, 1'b1, !HAZ, HAZ, "haz_rs2");
    applyStimulus(1'b1, mk(3'd0, 1'b0, 5'd1, 5'd0, 16'h4800), 1'b0, 1'b1, 1'b1, 1'b0, "haz_rs2_go");
    drain(HAZ_DEPTH + 1);

    // Write to r0: no write enable, and a following r0 reader never stalls.
    applyStimulus(1'b1, mk(3'd1, 1'b0, 5'd0, 5'd0, 16'h0000), 1'b0, 1'b1, 1'b1, 1'b0, "wr_r0");
    applyStimulus(1'b1, mk(3'd4, 1'b0, 5'd3, 5'd0, 16'h0000), 1'b0, 1'b1, 1'b1, 1'b0, "rd_r0");
    drain(HAZ_DEPTH + 1);

    // Flush drops both the held and the incoming instruction.
    applyStimulus(1'b1, mk(3'd2, 1'b1, 5'd8, 5'd0, 16'h0003), 1'b0, 1'b1, 1'b1, 1'b0, "fl_load");
    applyStimulus(1'b1, mk(3'd3, 1'b0, 5'd10, 5'd0, 16'h0005), 1'b1, 1'b0, 1'b1, 1'b0, "flush");
    applyStimulus(1'b1, mk(3'd0, 1'b0, 5'd6, 5'd8, 16'h0000), 1'b0, 1'b1, 1'b1, 1'b0, "fl_after");

    // Flush also empties the scoreboard.
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, "fl_sb_xfer");
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0, "fl_sb_flush");
    applyStimulus(1'b1, mk(3'd0, 1'b0, 5'd11, 5'd6, 16'h0000), 1'b0, 1'b1, 1'b1, 1'b0, "fl_sb_rd");

    // Asynchronous reset mid-cycle while an instruction is held.
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkVal("async out_valid", {31'd0, out_valid}, 32'd0);
    checkVal("async ws", {27'd0, ws}, 32'd0);
    checkVal("async rs1", {27'd0, rs1}, 32'd0);
    checkVal("async imm", immediate, 32'd0);
    checkVal("async op", {29'd0, alu_op}, 32'd0);
    checkVal("async in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.delete();
    model_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(1'b1, mk(3'd6, 1'b1, 5'd12, 5'd0, 16'h07F0), 1'b0, 1'b1, 1'b1, 1'b0, "post_rst");
    drain(2);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule

// File: doc/decode_stage_reg.md
DECODE_STAGE_REG -- requirements
Module: decode_stage_reg

Interface
REQ-001 Parameter INSTR_W, default 32: instruction word width.
REQ-002 Parameter REG_AW, default 5: register-select width.
REQ-003 Parameter IMM_W, default 16: raw immediate field width.
REQ-004 Parameter DATA_W, default 32: extended immediate width, SHALL be >= IMM_W.
REQ-005 Parameter OP_W, default 3: ALU opcode width.
REQ-006 Parameter HAZ_DEPTH, default 2: scoreboard depth in cycles, range 1..4.
REQ-007 clk  in  1  sole clock; all state updates on its rising edge.
REQ-008 rst  in  1  reset; asynchronous, active-high.
REQ-009 in_valid  in  1  instruction present on InstrIn.
REQ-010 InstrIn  in  INSTR_W  raw instruction word.
REQ-011 in_ready  out  1  stage accepts InstrIn this cycle.
REQ-012 flush  in  1  discard held and incoming instruction.
REQ-013 out_valid  out  1  decoded fields valid.
REQ-014 out_ready  in  1  downstream accepts decoded fields.
REQ-015 S1_ReadSelect1, S1_ReadSelect2, S1_WriteSelect  out  REG_AW each  decoded register selects.
REQ-016 S1_WriteEnable  out  1  registered write enable.
REQ-017 immediate  out  DATA_W  extended immediate.
REQ-018 data_src  out  1  operand source select.
REQ-019 ALU_OP  out  OP_W  ALU opcode.
REQ-020 stall  out  1  hazard interlock active (combinational).

Function
REQ-021 Field map at defaults: ReadSelect1=[20:16], ReadSelect2=[15:11], WriteSelect=[25:21], immediate raw=[15:0], data_src=[29], ALU_OP=[28:26]; field positions SHALL derive from parameters via package constants.
REQ-022 Single-entry holding register; load when in_valid && in_ready && !flush; latency one cycle from acceptance to out_valid.
REQ-023 in_ready = (!out_valid || out_ready) && !stall, forced 1 while flush is high.
REQ-024 Held fields SHALL remain stable while out_valid && !out_ready.
REQ-025 out_valid clears after transfer (out_valid && out_ready) when no new load occurs in the same cycle.
REQ-026 S1_WriteEnable = 1 only for an accepted instruction with WriteSelect != 0; 0 for bubbles and writes to register 0.
REQ-027 data_src=1: immediate sign-extended to DATA_W; data_src=0: zero-extended.
REQ-028 Scoreboard: HAZ_DEPTH-entry shift register of {valid, select}; shifts every cycle; new head = transferred instruction's WriteSelect with valid = its S1_WriteEnable, else invalid.
REQ-029 stall = in_valid && a nonzero incoming read select equals WriteSelect of a valid entry in the holding register (with S1_WriteEnable) or in any valid scoreboard entry.
REQ-030 flush: clears out_valid and all scoreboard valid bits next edge; overrides simultaneous load; instruction presented during flush is consumed and dropped.
REQ-031 Simultaneous transfer and load: new instruction replaces old in the same edge, out_valid stays 1.

Reset
REQ-032 On rst: all outputs 0, out_valid 0, scoreboard invalid; in_ready and stall evaluate from reset state (in_ready=1).
REQ-033 rst asserted mid-operation discards held instruction immediately, independent of clk.

Configuration
REQ-034 Macro DECODE_HAZARD_EN defined: scoreboard and stall per REQ-028/029.
REQ-035 DECODE_HAZARD_EN undefined: no scoreboard state; stall tied 0; in_ready per REQ-023 without the stall term.

Structure
REQ-036 Shared package decode_pkg: field offset/width constants, opcode width, decoded-fields struct typedef.
REQ-037 One sub-module decode_scoreboard (shift register plus match logic), instantiated only under DECODE_HAZARD_EN.

Verification
REQ-038 Reset: rst=1 async mid-cycle -> out_valid=0, all fields 0, in_ready=1 before next edge.
REQ-039 Decode: InstrIn=32'h2C22_8001, in_valid=1, out_ready=1 -> next cycle ReadSelect1=2, ReadSelect2=16, WriteSelect=1, data_src=1, ALU_OP=3, immediate=32'hFFFF_8001, WriteEnable=1.
REQ-040 Backpressure: out_ready=0 for 3 cycles with held instruction -> in_ready=0, fields stable, then transfer on out_ready=1.
REQ-041 Hazard (macro on): write r5 then instruction reading r5 -> stall=1 for HAZ_DEPTH+1 cycles, then accepted; reading r0 never stalls.
REQ-042 Flush: flush=1 with in_valid=1 and held instruction -> next cycle out_valid=0, stall=0, dropped instruction never appears.
REQ-043 Write to r0: WriteSelect=0 accepted -> S1_WriteEnable=0, no scoreboard entry, no subsequent stall.
